// File: rtl/uart_rx.sv
// Receive half of the simple UART: recovers 8N1 frames from an oversampled
// serial line into a one-word holding register with frame-error and overrun flags.
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 rxclk,
  input  logic                 reset,
  input  logic                 rx_enable,
  input  logic                 rx_in,
  input  logic                 uld_rx_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [2:0]           fsm_state
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                 state;
  logic [TICK_W-1:0]      tick;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   tick_max;
  logic                   half_pt;
  logic                   load_stb;

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
  end

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign tick_max  = (tick == TICK_W'(OVERSAMPLE - 1));
  assign half_pt   = (tick == TICK_W'(OVERSAMPLE / 2 - 1));
  assign load_stb  = rx_enable && (state == STOP) && tick_max;
  assign fsm_state = state;

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else if (!rx_enable) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tick    <= '0;
          bit_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          // Mid-start-bit check filters glitches shorter than half a bit.
          if (half_pt) begin
            tick  <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        DATA: begin
          tick <= tick_max ? '0 : tick + TICK_W'(1);
          if (tick_max) begin
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        STOP: begin
          tick <= tick_max ? '0 : tick + TICK_W'(1);
          if (tick_max) state <= rx_s ? IDLE : BREAK;
        end
        BREAK: begin
          tick <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A load in the same cycle as an unload wins; the old word counts as consumed.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      rx_data   <= '0;
      rx_empty  <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (load_stb) begin
      rx_data   <= shift;
      rx_empty  <= 1'b0;
      frame_err <= ~rx_s;
      if (!rx_empty) overrun <= ~uld_rx_data;
    end else if (uld_rx_data && !rx_empty) begin
      rx_empty <= 1'b1;
      overrun  <= 1'b0;
    end
  end

endmodule
